// File: rtl/rca_pkg.sv
// Shared types and elaboration helpers for the sequential ripple-carry add/subtract unit.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slice passes needed for one full-width operation.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A legal configuration splits the operand into whole, non-empty slices.
  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

  // Slice index counter width; a single-slice configuration still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca_seq_adder_if.sv
// Operand/result handshake bundle between producers, the adder and consumers.
interface rca_seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Operand producer / result consumer side.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Arithmetic unit side.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/rca_slice.sv
// Combinational CHUNK-bit ripple of full-adder cells; also exposes the carry into its top bit
// so the parent can form the signed-overflow flag on the final slice.
module rca_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  // Ripple the carry bit by bit from ci upward.
  always_comb begin
    // NOTE: every variable gets a value before the loop so no path leaves one unassigned (no latch).
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/rca_seq_adder.sv
// Multi-cycle ripple-carry add/subtract unit: one shared CHUNK-bit slice is stepped across the
// WIDTH-bit operands, one slice per clock, with valid/ready handshakes on both sides.
module rca_seq_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic            clk,
  input logic            rst,
  rca_seq_adder_if.slave bus
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("rca_seq_adder: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic             in_ready_r;

  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_s;
  logic             slice_co;
  logic             slice_cmsb;

  // Select the operand slice addressed by the current index.
  assign slice_a = a_r[idx*CHUNK +: CHUNK];
  assign slice_b = b_r[idx*CHUNK +: CHUNK];

  rca_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .ci    (carry_r),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  // Control FSM plus datapath registers; every output is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: operand registers are reset along with control so no X ever reaches the slice.
      state       <= IDLE;
      idx         <= '0;
      carry_r     <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (bus.in_valid && in_ready_r) begin
            // Subtract is a + ~b + 1: invert B once here and seed the carry with 1.
            a_r        <= bus.a;
            b_r        <= bus.sub ? ~bus.b : bus.b;
            carry_r    <= bus.sub ? 1'b1 : bus.cin;
            idx        <= '0;
            in_ready_r <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          sum_r[idx*CHUNK +: CHUNK] <= slice_s;
          carry_r                   <= slice_co;
          if (idx == LAST_IDX) begin
            cout_r      <= slice_co;
            ovf_r       <= slice_cmsb ^ slice_co;
            out_valid_r <= 1'b1;
            idx         <= '0;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_rca_seq_adder.sv
// Bench for rca_seq_adder: three instances (CHUNK = 4, 16, 1) at WIDTH = 16, each checked
// against an integer-arithmetic reference model.
module tb_rca_seq_adder;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  logic         in_valid_v  [3];
  logic [W-1:0] a_v         [3];
  logic [W-1:0] b_v         [3];
  logic         cin_v       [3];
  logic         sub_v       [3];
  logic         out_ready_v [3];
  logic         in_ready_o  [3];
  logic         out_valid_o [3];
  logic [W-1:0] sum_o       [3];
  logic         cout_o      [3];
  logic         ovf_o       [3];

  rca_seq_adder_if #(.WIDTH(W)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 4 : (g == 1) ? 16 : 1;
    assign bus[g].in_valid  = in_valid_v[g];
    assign bus[g].a         = a_v[g];
    assign bus[g].b         = b_v[g];
    assign bus[g].cin       = cin_v[g];
    assign bus[g].sub       = sub_v[g];
    assign bus[g].out_ready = out_ready_v[g];
    assign in_ready_o[g]    = bus[g].in_ready;
    assign out_valid_o[g]   = bus[g].out_valid;
    assign sum_o[g]         = bus[g].sum;
    assign cout_o[g]        = bus[g].cout;
    assign ovf_o[g]         = bus[g].ovf;

    rca_seq_adder #(.WIDTH(W), .CHUNK(CH)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 16;
  endfunction

  // Reference: plain integer arithmetic; returns {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    int ua, ub, sa, sb, ur, sr;
    logic co, ov;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      ur = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end else begin
      ur = ua + ub + int'(cin);
      sr = sa + sb + int'(cin);
      co = (ur > 65535);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, ur[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = 16'h0000;
      1:       v = 16'hFFFF;
      2:       v = 16'h7FFF;
      3:       v = 16'h8000;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on instance d; reports result, latency and accept time.
  task automatic do_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       output logic [W-1:0] sum, output logic cout, output logic ovf,
                       output int lat, output int acc_cyc, output bit ok);
    int n;
    ok = 1'b1; sum = '0; cout = 1'b0; ovf = 1'b0; lat = -1; acc_cyc = -1;
    n = 0;
    while (!in_ready_o[d] && n < 100) begin tick(); n++; end
    if (!in_ready_o[d]) begin
      vectors++; miscompares++; ok = 1'b0;
      $display("FAIL accept_timeout dut%0d: in_ready=%b, required 1 within 100 cycles", d, in_ready_o[d]);
      return;
    end
    a_v[d] = a; b_v[d] = b; cin_v[d] = cin; sub_v[d] = sub; in_valid_v[d] = 1'b1;
    acc_cyc = cyc;
    tick();
    in_valid_v[d] = 1'b0;
    lat = 0;
    while (!out_valid_o[d] && lat < 100) begin tick(); lat++; end
    if (!out_valid_o[d]) begin
      vectors++; miscompares++; ok = 1'b0;
      $display("FAIL result_timeout dut%0d: out_valid=%b, required 1 within 100 cycles", d, out_valid_o[d]);
      return;
    end
    sum = sum_o[d]; cout = cout_o[d]; ovf = ovf_o[d];
    out_ready_v[d] = 1'b1;
    tick();
    out_ready_v[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      in_valid_v[d] = 1'b0; a_v[d] = '0; b_v[d] = '0; cin_v[d] = 1'b0; sub_v[d] = 1'b0;
      out_ready_v[d] = 1'b0;
    end
    rst = 1'b1;
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({out_valid_o[d], sum_o[d], cout_o[d], ovf_o[d]} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d: out_valid=%b sum=%h cout=%b ovf=%b, required all 0",
                 d, out_valid_o[d], sum_o[d], cout_o[d], ovf_o[d]);
      end
    end
    rst = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (in_ready_o[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_in_ready dut%0d: in_ready=%b, required 1", d, in_ready_o[d]);
      end
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h0005, 16'h8000};
    logic [W-1:0] tb [5] = '{16'h0001, 16'h0001, 16'h0F0F, 16'h0007, 16'h0001};
    logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic         ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] es [5] = '{16'h0000, 16'h8000, 16'h2144, 16'hFFFE, 16'h7FFF};
    logic         ec [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic         eo [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] s;
    logic c, o;
    int lat, acc;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      do_op(0, ta[i], tb[i], tc[i], ts[i], s, c, o, lat, acc, ok);
      if (ok) begin
        vectors++;
        if (s !== es[i] || c !== ec[i] || o !== eo[i] || lat !== 4) begin
          miscompares++;
          $display("FAIL directed_%0d: sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=4",
                   i, s, c, o, lat, es[i], ec[i], eo[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, s;
    logic cin, sub, c, o;
    logic [W+1:0] exp;
    int lat, acc, prev;
    bit ok;
    for (int d = 0; d < 2; d++) begin
      prev = -1;
      for (int i = 0; i < 4; i++) begin
        a = rand_operand(); b = rand_operand(); cin = 1'($urandom); sub = 1'($urandom);
        exp = model(a, b, cin, sub);
        do_op(d, a, b, cin, sub, s, c, o, lat, acc, ok);
        if (!ok) break;
        vectors++;
        if ({o, c, s} !== exp) begin
          miscompares++;
          $display("FAIL b2b_result dut%0d: {ovf,cout,sum}=%h, required %h", d, {o, c, s}, exp);
        end
        if (prev >= 0) begin
          vectors++;
          if (acc - prev !== lat_of(d) + 2) begin
            miscompares++;
            $display("FAIL b2b_interval dut%0d: interval=%0d, required %0d", d, acc - prev, lat_of(d) + 2);
          end
        end
        prev = acc;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] xa = 16'h4321, xb = 16'h1111, ya = 16'h0F00, yb = 16'h00F0;
    logic [W+1:0] ex, ey;
    int n;
    ex = model(xa, xb, 1'b0, 1'b1);
    ey = model(ya, yb, 1'b1, 1'b0);
    n = 0;
    while (!in_ready_o[0] && n < 20) begin tick(); n++; end
    a_v[0] = xa; b_v[0] = xb; cin_v[0] = 1'b0; sub_v[0] = 1'b1; in_valid_v[0] = 1'b1;
    tick();
    in_valid_v[0] = 1'b0;
    n = 0;
    while (!out_valid_o[0] && n < 20) begin tick(); n++; end
    vectors++;
    if (out_valid_o[0] !== 1'b1 || {ovf_o[0], cout_o[0], sum_o[0]} !== ex) begin
      miscompares++;
      $display("FAIL bp_first_result: out_valid=%b {ovf,cout,sum}=%h, required 1 %h",
               out_valid_o[0], {ovf_o[0], cout_o[0], sum_o[0]}, ex);
    end
    // Present new operands while the consumer stalls.
    a_v[0] = ya; b_v[0] = yb; cin_v[0] = 1'b1; sub_v[0] = 1'b0; in_valid_v[0] = 1'b1;
    out_ready_v[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (out_valid_o[0] !== 1'b1 || in_ready_o[0] !== 1'b0 || {ovf_o[0], cout_o[0], sum_o[0]} !== ex) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b {ovf,cout,sum}=%h, required 1 0 %h",
                 i, out_valid_o[0], in_ready_o[0], {ovf_o[0], cout_o[0], sum_o[0]}, ex);
      end
    end
    out_ready_v[0] = 1'b1;
    tick();
    out_ready_v[0] = 1'b0;
    vectors++;
    if (out_valid_o[0] !== 1'b0 || in_ready_o[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid_o[0], in_ready_o[0]);
    end
    tick();
    in_valid_v[0] = 1'b0;
    vectors++;
    if (in_ready_o[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accept_new: in_ready=%b, required 0", in_ready_o[0]);
    end
    n = 0;
    while (!out_valid_o[0] && n < 20) begin tick(); n++; end
    vectors++;
    if (n !== 4 || {ovf_o[0], cout_o[0], sum_o[0]} !== ey) begin
      miscompares++;
      $display("FAIL bp_second_result: lat=%0d {ovf,cout,sum}=%h, required lat=4 %h",
               n, {ovf_o[0], cout_o[0], sum_o[0]}, ey);
    end
    out_ready_v[0] = 1'b1;
    tick();
    out_ready_v[0] = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] s;
    logic c, o;
    int lat, acc;
    bit ok;
    do_op(0, 16'hA5A5, 16'h0000, 1'b0, 1'b0, s, c, o, lat, acc, ok);
    a_v[0] = 16'h1234; b_v[0] = 16'h0101; cin_v[0] = 1'b0; sub_v[0] = 1'b0; in_valid_v[0] = 1'b1;
    tick();
    in_valid_v[0] = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid_o[0] !== 1'b0 || sum_o[0] !== '0 || cout_o[0] !== 1'b0 || ovf_o[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_op: out_valid=%b sum=%h cout=%b ovf=%b, required 0 0000 0 0",
               out_valid_o[0], sum_o[0], cout_o[0], ovf_o[0]);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (in_ready_o[0] !== 1'b1 || out_valid_o[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_release: in_ready=%b out_valid=%b, required 1 0", in_ready_o[0], out_valid_o[0]);
    end
    do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, s, c, o, lat, acc, ok);
    if (ok) begin
      vectors++;
      if (s !== 16'h0100 || c !== 1'b0 || o !== 1'b0 || lat !== 4) begin
        miscompares++;
        $display("FAIL rst_next_op: sum=%h cout=%b ovf=%b lat=%0d, required 0100 0 0 4", s, c, o, lat);
      end
    end
  endtask

  task automatic test_config_sweep();
    logic [W-1:0] a, b, s;
    logic cin, sub, c, o;
    logic [W+1:0] exp;
    int lat, acc, nops;
    bit ok;
    for (int d = 0; d < 3; d++) begin
      nops = (d == 0) ? 200 : 1000;
      for (int i = 0; i < nops; i++) begin
        a = rand_operand(); b = rand_operand(); cin = 1'($urandom); sub = 1'($urandom);
        exp = model(a, b, cin, sub);
        do_op(d, a, b, cin, sub, s, c, o, lat, acc, ok);
        if (!ok) break;
        vectors++;
        if ({o, c, s} !== exp || lat !== lat_of(d)) begin
          miscompares++;
          $display("FAIL sweep dut%0d a=%h b=%h cin=%b sub=%b: {ovf,cout,sum}=%h lat=%0d, required %h lat=%0d",
                   d, a, b, cin, sub, {o, c, s}, lat, exp, lat_of(d));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_config_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
